// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Hazard and forwarding unit for the pipelined datapath. It works out the
// operand and store-data forwarding selects across DEPTH downstream stages,
// load-use stalls, and a per-register scoreboard for fixed-latency
// multi-cycle ops. It also handles the memory-wait freeze, branch flush
// control and a saturating stall-cycle counter.
//
// Ports:
//   CLK, RST                  clock (rising edge), asynchronous active-high reset
//   id_rs/id_rt, id_use_*     IF/ID source registers and their use bits
//   ex_rs/ex_rt/ex_rd         ID/EX sources and destination
//   ex_regwrite/ex_dren/ex_mc ID/EX writes a register / is a load / is multi-cycle
//   st_regwrite, st_rd        per downstream stage RegWrite and destination (k = 0 is EX/MEM)
//   mem_dwen, mem_rt          EX/MEM store and its store-data register
//   mem_wait, branch_taken    data memory not ready / branch resolved taken in EX
//   fwd_a, fwd_b              operand select: 0 = register file, k+1 = stage k
//   fwd_st                    store-data select: 0 = EX/MEM value, k = stage k
//   stall_id, freeze          bubble into ID/EX / hold every pipeline register
//   flush_ifid, flush_idex    zero IF/ID and ID/EX
//   stall_cnt                 saturating count of stall or freeze cycles
module hazard_scoreboard #(
    parameter int NREG   = 32,
    parameter int RW     = 5,
    parameter int DEPTH  = 3,
    parameter int MC_LAT = 4,
    parameter int CW     = 16,
    localparam int FW    = $clog2(DEPTH + 1),
    localparam int SW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [RW-1:0]       id_rs,
    input  logic [RW-1:0]       id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic [RW-1:0]       ex_rs,
    input  logic [RW-1:0]       ex_rt,
    input  logic [RW-1:0]       ex_rd,
    input  logic                ex_regwrite,
    input  logic                ex_dren,
    input  logic                ex_mc,
    input  logic [DEPTH-1:0]    st_regwrite,
    input  logic [DEPTH*RW-1:0] st_rd,
    input  logic                mem_dwen,
    input  logic [RW-1:0]       mem_rt,
    input  logic                mem_wait,
    input  logic                branch_taken,
    output logic [FW-1:0]       fwd_a,
    output logic [FW-1:0]       fwd_b,
    output logic [SW-1:0]       fwd_st,
    output logic                stall_id,
    output logic                freeze,
    output logic                flush_ifid,
    output logic                flush_idex,
    output logic [CW-1:0]       stall_cnt
);

    localparam int CNTW = $clog2(MC_LAT + 1);
    localparam logic [CNTW-1:0] LAT_C = CNTW'(MC_LAT);

    logic [CNTW-1:0] sb_r [NREG];
    logic [CW-1:0]   stall_cnt_r;

    logic [FW-1:0] fwd_a_s;
    logic [FW-1:0] fwd_b_s;
    logic [SW-1:0] fwd_st_s;
    logic          rs_used_s;
    logic          rt_used_s;
    logic          luse_s;
    logic          ex_mc_pend_s;
    logic          mcuse_s;
    logic          issue_s;

    // Forwarding selects: scan from the farthest stage inward so the nearest match wins.
    always_comb begin
        fwd_a_s  = '0;
        fwd_b_s  = '0;
        fwd_st_s = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            fwd_a_s = (st_regwrite[k] && (st_rd[k*RW +: RW] != '0) && (st_rd[k*RW +: RW] == ex_rs))
                      ? FW'(k + 1) : fwd_a_s;
            fwd_b_s = (st_regwrite[k] && (st_rd[k*RW +: RW] != '0) && (st_rd[k*RW +: RW] == ex_rt))
                      ? FW'(k + 1) : fwd_b_s;
        end
        // Stage 0 is never a store-data source: the store itself sits in EX/MEM.
        if (mem_dwen) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                fwd_st_s = (st_regwrite[k] && (st_rd[k*RW +: RW] != '0) && (st_rd[k*RW +: RW] == mem_rt))
                           ? SW'(k) : fwd_st_s;
            end
        end else begin
            fwd_st_s = '0;
        end
    end

    // Hazard detection: load-use and scoreboard (multi-cycle) dependencies of the ID instruction.
    always_comb begin
        rs_used_s    = id_use_rs && (id_rs != '0);
        rt_used_s    = id_use_rt && (id_rt != '0);
        ex_mc_pend_s = ex_mc && ex_regwrite && (ex_rd != '0);
        luse_s       = ex_dren && (ex_rd != '0) &&
                       ((rs_used_s && (id_rs == ex_rd)) || (rt_used_s && (id_rt == ex_rd)));
        // A producer still in EX has not loaded its counter yet, so match it directly.
        mcuse_s      = (rs_used_s && ((sb_r[id_rs] != '0) || (ex_mc_pend_s && (id_rs == ex_rd)))) ||
                       (rt_used_s && ((sb_r[id_rt] != '0) || (ex_mc_pend_s && (id_rt == ex_rd))));
        // A taken branch squashes the ID/EX contents, so a multi-cycle op there never issues.
        issue_s      = ex_mc_pend_s && !branch_taken;
    end

    // Output priority: memory freeze over branch flush over hazard stall; all quiet in reset.
    always_comb begin
        fwd_a      = '0;
        fwd_b      = '0;
        fwd_st     = '0;
        stall_id   = 1'b0;
        freeze     = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (RST) begin
            freeze = 1'b0;
        end else begin
            fwd_a  = fwd_a_s;
            fwd_b  = fwd_b_s;
            fwd_st = fwd_st_s;
            if (mem_wait) begin
                freeze = 1'b1;
            end else if (branch_taken) begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end else begin
                stall_id = luse_s || mcuse_s;
            end
        end
    end

    // Scoreboard counters: load on issue, otherwise count down; everything holds while frozen.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                sb_r[i] <= '0;
            end
        end else if (!mem_wait) begin
            for (int i = 0; i < NREG; i++) begin
                if (issue_s && (ex_rd == RW'(i))) begin
                    sb_r[i] <= LAT_C;
                end else if (sb_r[i] != '0) begin
                    sb_r[i] <= sb_r[i] - CNTW'(1);
                end else begin
                    sb_r[i] <= sb_r[i];
                end
            end
        end
    end

    // Stall/freeze cycle counter, saturating at all ones.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_r <= '0;
        end else if ((stall_id || freeze) && (stall_cnt_r != {CW{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CW'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;

endmodule
